// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared tap masks, FSM state type and single-step LFSR helper
package lfsr_pkg;
    localparam logic [15:0] TAPS_16 = 16'hD008;
    localparam logic [31:0] TAPS_32 = 32'hA300_0000;
    localparam logic [63:0] TAPS_64 = 64'hD800_0000_0000_0000;

    typedef enum logic {FILL, VALID} rng_state_e;

    typedef struct packed {
        logic        fb;
        logic [63:0] state;
    } step_t;

    function automatic step_t lfsr_step(input logic [63:0] state, input logic [63:0] taps, input int unsigned width);
        step_t r;
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        r.fb = ^(state & taps & mask);
        r.state = ((state << 1) | {63'd0, r.fb}) & mask;
        return r;
    endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci LFSR register with unrolled multi-step, seed load and lockup guard
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int              W            = 16,
    parameter logic [W-1:0]    TAPS         = 16'hD008,
    parameter logic [W-1:0]    DEFAULT_SEED = 16'hA65A,
    parameter int              B            = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         seed_load,
    input  logic [W-1:0] seed_in,
    output logic [W-1:0] state,
    output logic [B-1:0] fb,
    output logic         zero_reload
);
    logic [W-1:0] cur;
    step_t r;

    assign zero_reload = (state == '0) && !seed_load;

    // B chained steps; the first feedback bit lands in the MSB of fb
    always_comb begin
        cur = state;
        fb = '0;
        r = '0;
        for (int i = 0; i < B; i++) begin
            r = lfsr_step(64'(cur), 64'(TAPS), W);
            fb = (fb << 1) | B'(r.fb);
            cur = W'(r.state);
        end
    end

    // seed load beats the lockup guard, which beats a normal advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= DEFAULT_SEED;
        else if (seed_load)
            state <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
        else if (zero_reload)
            state <= DEFAULT_SEED;
        else if (advance)
            state <= cur;
    end
endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: LFSR-based random word generator with valid/ready delivery
// Optional feature macro RSA_PRIME_FMT_EN: forces MSB/LSB of delivered words to 1 and adds reject_zero_cnt
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH     = 16,
    parameter logic [LFSR_WIDTH-1:0] TAPS           = 16'hD008,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED   = 16'hA65A,
    parameter int                    OUT_WIDTH      = 32,
    parameter int                    BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    output logic                  rand_valid,
    input  logic                  rand_ready,
    output logic [OUT_WIDTH-1:0]  rand_out,
    output logic [LFSR_WIDTH-1:0] lfsr_state
`ifdef RSA_PRIME_FMT_EN
    ,
    output logic [7:0]            reject_zero_cnt
`endif
);
    localparam int STEPS = OUT_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    rng_state_e state, state_nx;
    logic [CW-1:0] cnt;
    logic [OUT_WIDTH-1:0] acc;
    logic [BITS_PER_CYCLE-1:0] fb;
    logic adv, take, zero_reload;

    assign rand_valid = state == VALID;
    assign take = rand_valid && rand_ready;
    assign adv = state == FILL && enable && !seed_load && !zero_reload;

    lfsr_core #(
        .W(LFSR_WIDTH),
        .TAPS(TAPS),
        .DEFAULT_SEED(DEFAULT_SEED),
        .B(BITS_PER_CYCLE)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .advance(adv),
        .seed_load(seed_load),
        .seed_in(seed_in),
        .state(lfsr_state),
        .fb(fb),
        .zero_reload(zero_reload)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nx;
    end

    // next state: seed load discards everything, otherwise fill to VALID and wait for handshake
    always_comb begin
        state_nx = state;
        state_nx = seed_load ? FILL : (adv && cnt == LAST) ? VALID : take ? FILL : state;
    end

    // accumulator and step counter; both frozen outside enabled FILL cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
        end else if (seed_load) begin
            cnt <= '0;
            acc <= '0;
        end else if (adv) begin
            acc <= {acc[OUT_WIDTH-BITS_PER_CYCLE-1:0], fb};
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else if (take) begin
            cnt <= '0;
        end
    end

`ifdef RSA_PRIME_FMT_EN
    assign rand_out = rand_valid ? (acc | {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1}) : acc;

    // saturating count of lockup-guard reloads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            reject_zero_cnt <= '0;
        else if (zero_reload && reject_zero_cnt != 8'hFF)
            reject_zero_cnt <= reject_zero_cnt + 8'd1;
    end
`else
    assign rand_out = acc;
`endif
endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
- Parametrised pseudo-random word generator built on a Fibonacci LFSR.
- The LFSR has configurable width and tap mask, and advances several bits per clock.
- Output words are accumulated to a configurable width and delivered over a valid/ready handshake.
- A runtime seed-load port is provided, and the all-zero lockup state is guarded against.
- Feeds the RSA candidate/nonce path. Not cryptographically secure; test and bring-up use only.

Parameters:
- LFSR_WIDTH, 16, state register width (≥3).
- TAPS, 16'hD008, feedback tap mask; bit i set means lfsr[i] is XORed into feedback (x^16+x^15+x^13+x^4+1).
- DEFAULT_SEED, 16'hA65A, reset state and zero-seed substitute; must be nonzero.
- OUT_WIDTH, 32, width of each delivered word.
- BITS_PER_CYCLE, 1, LFSR steps per clock; must divide OUT_WIDTH and be ≤ LFSR_WIDTH.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, LFSR advances only while high.
- seed_load, in, 1, single-cycle pulse: load seed_in.
- seed_in, in, LFSR_WIDTH, new seed.
- rand_valid, out, 1, rand_out holds a complete word.
- rand_ready, in, 1, consumer accepts the word.
- rand_out, out, OUT_WIDTH, random word.
- lfsr_state, out, LFSR_WIDTH, current LFSR state (debug).

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk.
  - While reset is asserted: lfsr = DEFAULT_SEED, fill counter = 0, state = FILL, rand_valid = 0, rand_out = 0.
- Single step: fb = ^(lfsr & TAPS); lfsr_next = {lfsr[LFSR_WIDTH-2:0], fb}.
  - One clock applies BITS_PER_CYCLE unrolled steps.
  - The fb bits produced are shifted into the accumulator LSB-first in order (first fb ends up highest after the word completes): acc <= {acc[OUT_WIDTH-BITS_PER_CYCLE-1:0], fb_0..fb_{B-1}}.
- FSM, 2 states:
  - FILL: each cycle with enable=1, advance the LFSR, shift the accumulator and increment the counter.
    - When the counter reaches OUT_WIDTH/BITS_PER_CYCLE-1 on an enabled cycle, the next state is VALID; rand_out = acc and rand_valid = 1 from the following cycle.
    - enable=0 freezes the LFSR, accumulator and counter.
  - VALID: rand_out is held stable and the LFSR does not advance (regardless of enable).
    - On rand_valid & rand_ready: rand_valid = 0 next cycle, counter = 0, return to FILL.
- Latency: with enable held high, the first rand_valid rises OUT_WIDTH/BITS_PER_CYCLE cycles after reset release. Each subsequent word arrives OUT_WIDTH/BITS_PER_CYCLE+1 cycles after the accepting handshake.
- rand_ready while rand_valid=0 is ignored. rand_valid never drops without a handshake, except on seed_load or reset.
- seed_load (highest priority after reset, any state):
  - lfsr <= (seed_in==0) ? DEFAULT_SEED : seed_in.
  - Counter and accumulator cleared, rand_valid <= 0, state <= FILL. Any partially filled or pending word is discarded.
  - No advance occurs in the load cycle.
  - seed_load together with a handshake: the load wins and the word counts as consumed.
- Lockup guard: if lfsr is ever all-zero (not reachable under correct operation), it is reloaded with DEFAULT_SEED on the next clock.
- Counter width: $clog2(OUT_WIDTH/BITS_PER_CYCLE+1). Wrap-around is impossible because the counter is cleared on every FILL entry.

Optional Feature:
- Macro: RSA_PRIME_FMT_EN.
- Defined: the delivered rand_out has bits [OUT_WIDTH-1] and [0] forced to 1 (odd, full-length prime candidate), and the accumulator is unchanged.
  - Also adds output reject_zero_cnt (8 bits, saturating), which counts lockup-guard reloads.
- Undefined: rand_out = acc unmodified and reject_zero_cnt is absent.

Decomposition:
- Package lfsr_pkg holds:
  - Default tap masks per common width (16, 32, 64) as localparams.
  - Enum rng_state_e {FILL, VALID}.
  - Function lfsr_step(state, taps) returning the next state and fb bit; used by both RTL and the testbench model.
- One natural sub-module, lfsr_core: the state register, unrolled multi-step, seed load and lockup guard. It outputs state plus the BITS_PER_CYCLE fb bits.
- lfsr_rng wraps lfsr_core with the accumulator, counter, FSM and handshake.

Test Plan:
- Reset release, enable=1, ready=1, defaults:
  - rand_valid rises exactly 32 cycles later.
  - rand_out matches the software lfsr_step model seeded with 0xA65A.
  - lfsr_state after reset = 0xA65A.
- Period:
  - seed 0x0001, BITS_PER_CYCLE=1, step 65535 times → lfsr_state returns to 0x0001 and no earlier repeat occurs.
- Backpressure:
  - hold rand_ready=0 for 50 cycles after valid → rand_out and lfsr_state remain constant.
  - Raise ready → valid drops the next cycle and the next word arrives 33 cycles after the handshake.
- Seed load:
  - pulse seed_load with seed_in=0x0000 mid-fill → lfsr_state=0xA65A next cycle and valid=0.
  - seed_in=0x1234 while in VALID → word discarded and refill starts from 0x1234.
- Multi-bit:
  - BITS_PER_CYCLE=4, OUT_WIDTH=32 → valid after 8 cycles.
  - The word is bit-identical to the BITS_PER_CYCLE=1 word from the same seed.
- enable=0 for 10 cycles mid-fill → valid is delayed by exactly 10 cycles and the word is unchanged.
  - With RSA_PRIME_FMT_EN: rand_out[31]=1 and rand_out[0]=1 on every word.
